// File: rtl/bmem_arb_pkg.sv
// Shared types and constants for the burst-memory arbiter and its users.
package bmem_arb_pkg;

    localparam int LINE_W     = 256;
    localparam int BEAT_W     = 64;
    localparam int ADDR_W     = 32;
    localparam int LINE_OFF_W = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_CMD   = 3'd1,
        RD_WAIT  = 3'd2,
        WR_BURST = 3'd3,
        RESP     = 3'd4
    } arb_state_t;

    // True when two byte addresses fall in the same 32-byte line.
    function automatic logic tag_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return (a[ADDR_W-1:LINE_OFF_W] == b[ADDR_W-1:LINE_OFF_W]);
    endfunction

endpackage

// File: rtl/bmem_arbiter_if.sv
// Burst memory port bundle: master drives commands/write beats, slave returns read beats.
interface bmem_arbiter_if;
    import bmem_arb_pkg::*;

    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport master (
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport slave (
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: one-hot grant of the first pending
// requester at or after the pointer, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               valid_o
);

    logic [PTR_W-1:0] wrap_idx_s;
    logic             hit_s;

    // Walk the requesters starting at the pointer; the first pending one wins.
    always_comb begin
        grant_o    = '0;
        valid_o    = 1'b0;
        wrap_idx_s = '0;
        hit_s      = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            wrap_idx_s          = PTR_W'((int'(ptr_i) + off) % NUM_REQ);
            hit_s               = pending_i[wrap_idx_s] & ~valid_o;
            grant_o[wrap_idx_s] = grant_o[wrap_idx_s] | hit_s;
            valid_o             = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/bmem_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one 64-bit burst memory
// port among NUM_REQ cache line requesters. One transaction at a time:
// line reads are a single command followed by BEATS tagged return beats,
// line writes are BEATS back-to-back strobed beats. Completion is a
// one-cycle pulse to the granted requester with the assembled read line.
module bmem_arbiter
    import bmem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BEATS   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]             req_read_i,
    input  logic [NUM_REQ-1:0]             req_write_i,
    input  logic [NUM_REQ-1:0][LINE_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]             req_resp_o,
    output logic [LINE_W-1:0]              req_rdata_o,
    bmem_arbiter_if.master                 bmem
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Architectural state
    arb_state_t         state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   grant_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]  line_q;
    logic [CNT_W-1:0]   cnt_q;

    // Registered outputs
    logic [ADDR_W-1:0]  bmem_addr_q;
    logic               bmem_read_q;
    logic               bmem_write_q;
    logic [BEAT_W-1:0]  bmem_wdata_q;
    logic [NUM_REQ-1:0] resp_q;
    logic [LINE_W-1:0]  rdata_q;

    // Combinational helpers
    logic [NUM_REQ-1:0] pending_s;
    logic [NUM_REQ-1:0] pick_oh_s;
    logic               pick_valid_s;
    logic [PTR_W-1:0]   pick_idx_d;
    logic [PTR_W-1:0]   ptr_next_d;
    logic [CNT_W-1:0]   cnt_inc_d;
    logic [LINE_W-1:0]  line_fill_d;
    logic [BEAT_W-1:0]  wbeat_next_d;
    logic               last_beat_s;
    logic               tag_hit_s;
    logic               unused_raddr_s;

    assign pending_s   = req_read_i | req_write_i;
    assign cnt_inc_d   = cnt_q + CNT_W'(1);
    assign last_beat_s = (cnt_q == CNT_W'(BEATS - 1));
    assign tag_hit_s   = bmem.bmem_rvalid & tag_match(bmem.bmem_raddr, addr_q);
    assign ptr_next_d  = (grant_q == PTR_W'(NUM_REQ - 1)) ? PTR_W'(0) : (grant_q + PTR_W'(1));

    // Offset bits of the return tag carry no information for a line match.
    assign unused_raddr_s = ^bmem.bmem_raddr[LINE_OFF_W-1:0];

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .pending_i (pending_s),
        .ptr_i     (ptr_q),
        .grant_o   (pick_oh_s),
        .valid_o   (pick_valid_s)
    );

    // Encode the one-hot pick into an index for latching and indexing.
    always_comb begin
        pick_idx_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_idx_d = pick_idx_d | (pick_oh_s[i] ? PTR_W'(i) : PTR_W'(0));
        end
    end

    // Line buffer with the incoming read beat dropped into the current slot.
    always_comb begin
        line_fill_d = line_q;
        for (int k = 0; k < BEATS; k++) begin
            line_fill_d[k*BEAT_W +: BEAT_W] = (cnt_q == CNT_W'(k)) ? bmem.bmem_rdata
                                                                   : line_q[k*BEAT_W +: BEAT_W];
        end
    end

    // Write beat that follows the current one in the latched line.
    always_comb begin
        wbeat_next_d = '0;
        for (int k = 0; k < BEATS; k++) begin
            wbeat_next_d = wbeat_next_d | ((cnt_inc_d == CNT_W'(k)) ? line_q[k*BEAT_W +: BEAT_W]
                                                                    : {BEAT_W{1'b0}});
        end
    end

    // Arbitration FSM: grant, burst sequencing, line assembly and the response pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            addr_q       <= '0;
            line_q       <= '0;
            cnt_q        <= '0;
            bmem_addr_q  <= '0;
            bmem_read_q  <= 1'b0;
            bmem_write_q <= 1'b0;
            bmem_wdata_q <= '0;
            resp_q       <= '0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid_s) begin
                        grant_q     <= pick_idx_d;
                        addr_q      <= req_addr_i[pick_idx_d];
                        bmem_addr_q <= req_addr_i[pick_idx_d];
                        cnt_q       <= '0;
                        // A requester raising both read and write gets the write.
                        if (req_write_i[pick_idx_d]) begin
                            line_q       <= req_wdata_i[pick_idx_d];
                            bmem_write_q <= 1'b1;
                            bmem_wdata_q <= req_wdata_i[pick_idx_d][BEAT_W-1:0];
                            state_q      <= WR_BURST;
                        end else begin
                            line_q      <= '0;
                            bmem_read_q <= 1'b1;
                            state_q     <= RD_CMD;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end

                RD_CMD: begin
                    if (bmem.bmem_ready) begin
                        bmem_read_q <= 1'b0;
                        bmem_addr_q <= '0;
                        state_q     <= RD_WAIT;
                    end else begin
                        state_q <= RD_CMD;
                    end
                end

                RD_WAIT: begin
                    // Beats tagged for some other line are simply dropped.
                    if (tag_hit_s) begin
                        line_q <= line_fill_d;
                        if (last_beat_s) begin
                            cnt_q   <= '0;
                            rdata_q <= line_fill_d;
                            resp_q  <= NUM_REQ'(1) << grant_q;
                            ptr_q   <= ptr_next_d;
                            state_q <= RESP;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end else begin
                        state_q <= RD_WAIT;
                    end
                end

                WR_BURST: begin
                    // Without ready the current beat is held exactly as presented.
                    if (bmem.bmem_ready) begin
                        if (last_beat_s) begin
                            cnt_q        <= '0;
                            bmem_write_q <= 1'b0;
                            bmem_wdata_q <= '0;
                            bmem_addr_q  <= '0;
                            rdata_q      <= '0;
                            resp_q       <= NUM_REQ'(1) << grant_q;
                            ptr_q        <= ptr_next_d;
                            state_q      <= RESP;
                        end else begin
                            cnt_q        <= cnt_inc_d;
                            bmem_wdata_q <= wbeat_next_d;
                        end
                    end else begin
                        state_q <= WR_BURST;
                    end
                end

                RESP: begin
                    resp_q  <= '0;
                    rdata_q <= '0;
                    state_q <= IDLE;
                end

                default: begin
                    bmem_read_q  <= 1'b0;
                    bmem_write_q <= 1'b0;
                    bmem_addr_q  <= '0;
                    bmem_wdata_q <= '0;
                    resp_q       <= '0;
                    rdata_q      <= '0;
                    cnt_q        <= '0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign bmem.bmem_addr  = bmem_addr_q;
    assign bmem.bmem_read  = bmem_read_q;
    assign bmem.bmem_write = bmem_write_q;
    assign bmem.bmem_wdata = bmem_wdata_q;
    assign req_resp_o      = resp_q;
    assign req_rdata_o     = rdata_q;

endmodule
